access_permission_ctrl: RTL and testbench
=========================================

// Module: access_permission_ctrl
// PURPOSE
//   Sequential, parametrised successor to the combinational permission authenticator.
//   - Accepts user-level / file-level / requested-operation triples over a valid/ready handshake.
//   - Computes the R/W/X permission vector and returns one registered grant/deny response per request.
//   - Counts consecutive denials; after MAX_FAILS of them it enters a timed lockout that refuses new requests.
//   - Sits between the keypad/user front end and the file-access datapath of the controller.
// PARAMETERS
//   LEVEL_W      3   width of user and file security levels (levels 0..2^LEVEL_W-1)
//   MAX_FAILS    3   consecutive denials that trigger lockout (>=1)
//   LOCK_CYCLES  16  clock cycles spent in lockout (>=1)
// PORTS
//   clk        in   1            system clock, rising edge
//   rst_n      in   1            asynchronous active-low reset
//   req_valid  in   1            request present
//   req_ready  out  1            controller can accept a request
//   req_user   in   LEVEL_W      requesting user level
//   req_file   in   LEVEL_W      target file level
//   req_op     in   3            requested ops: [0]=read [1]=write [2]=exec (any combination)
//   rsp_valid  out  1            response present
//   rsp_ready  in   1            consumer takes response
//   rsp_grant  out  1            1 = every requested op permitted
//   rsp_perm   out  3            full permission vector for the pair (R,W,X in bits 0,1,2)
//   locked     out  1            high while in LOCK state
//   fail_cnt   out  $clog2(MAX_FAILS+1)  current consecutive-denial count
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; req_ready=0 while rst_n low, 1 in first cycle after release.
//     rsp_valid=0, rsp_grant=0, rsp_perm=0, locked=0, fail_cnt=0, lock counter=0.
//     Reset mid-transaction drops any pending response.
//   Permission rule, with u=req_user, f=req_file, TOP=2^LEVEL_W-1 (unsigned compare):
//     u==TOP -> perm=3'b111.
//     Otherwise R=(u>=f), W=(u>f), X=(u>=f)&&f[0].
//   grant = (req_op!=0) && ((req_op & ~perm)==0). req_op==0 -> grant=0, not counted as a failure.
//   FSM states and transitions:
//     IDLE: req_ready=1. On req_valid && req_ready, latch result -> RESP.
//       rsp_valid=1 in the cycle after acceptance (latency 1).
//     RESP: req_ready=0. rsp_valid, rsp_grant and rsp_perm are held stable until rsp_ready.
//       On handshake (rsp_valid && rsp_ready), fail_cnt updates:
//         grant -> 0; deny with req_op!=0 -> +1 (saturating at MAX_FAILS); req_op==0 -> unchanged.
//       If the new fail_cnt==MAX_FAILS -> LOCK; otherwise -> IDLE.
//       rsp_valid falls in the next cycle.
//     LOCK: req_ready=0, locked=1. Lock counter counts 0..LOCK_CYCLES-1.
//       At terminal count -> IDLE with fail_cnt=0 and counter=0.
//       Requests arriving during lock are not accepted (held off by req_ready=0).
//   Exactly one request is in flight; back-to-back throughput is 1 request per 2 cycles (rsp_ready held 1).
//   Inputs are sampled only at acceptance; later changes do not affect the pending response.
//   rsp_perm is reported on deny as well as grant.
// TESTING
//   1 Reset: assert rst_n=0 mid-RESP -> rsp_valid=0, fail_cnt=0; after release, req_ready=1 in the next cycle.
//   2 Grant: LEVEL_W=3, u=5, f=3, op=3'b011
//       -> rsp_valid one cycle after accept, rsp_perm=3'b111, rsp_grant=1, fail_cnt stays 0.
//   3 Deny/backpressure: u=2, f=2, op=3'b010 with rsp_ready low 4 cycles
//       -> rsp_perm=3'b001, rsp_grant=0 held stable, req_ready=0.
//       On handshake fail_cnt=1.
//   4 Lockout: three consecutive denials
//       -> locked=1 for exactly 16 cycles, req_ready=0, then IDLE with fail_cnt=0.
//       A request during lock is accepted only after exit.
//   5 Admin/edge: u=7, f=7, op=3'b111 -> grant, perm=3'b111.
//       op=3'b000 -> grant=0 and fail_cnt unchanged.
//       A grant after two denials clears fail_cnt to 0.

Source files
------------

// File: rtl/access_permission_ctrl.sv
// Sequential permission checker: one request in flight over valid/ready handshakes,
// with a consecutive-denial counter that triggers a timed lockout.
module access_permission_ctrl #(
  parameter  int LEVEL_W     = 3,
  parameter  int MAX_FAILS   = 3,
  parameter  int LOCK_CYCLES = 16,
  localparam int FC_W        = $clog2(MAX_FAILS + 1),
  localparam int LC_W        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [LEVEL_W-1:0] req_user,
  input  logic [LEVEL_W-1:0] req_file,
  input  logic [2:0]         req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_grant,
  output logic [2:0]         rsp_perm,
  output logic               locked,
  output logic [FC_W-1:0]    fail_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [LEVEL_W-1:0] TOP       = {LEVEL_W{1'b1}};
  localparam logic [FC_W-1:0]    FAIL_MAX  = FC_W'(MAX_FAILS);
  localparam logic [LC_W-1:0]    LOCK_LAST = LC_W'(LOCK_CYCLES - 1);

  state_t          state, state_nxt;
  logic [FC_W-1:0] fail_nxt;
  logic [LC_W-1:0] lock_cnt, lock_nxt;
  logic            op_zero_q;
  logic            load_rsp;
  logic [2:0]      perm_c;
  logic            grant_c;
  logic            ready_q;

  // Level 0..TOP-1 users follow the read-down / write-strictly-down rule;
  // execute additionally requires an odd file level.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    perm_c = 3'b000;
    if (req_user == TOP) begin
      perm_c = 3'b111;
    end else begin
      perm_c[0] = (req_user >= req_file);
      perm_c[1] = (req_user >  req_file);
      perm_c[2] = (req_user >= req_file) && req_file[0];
    end
  end

  assign grant_c = (req_op != 3'b000) && ((req_op & ~perm_c) == 3'b000);

  always_comb begin
    state_nxt = state;
    fail_nxt  = fail_cnt;
    lock_nxt  = lock_cnt;
    load_rsp  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          load_rsp  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (rsp_grant) begin
            fail_nxt = '0;
          end else if (!op_zero_q && (fail_cnt != FAIL_MAX)) begin
            fail_nxt = fail_cnt + FC_W'(1);
          end
          lock_nxt  = '0;
          state_nxt = (fail_nxt == FAIL_MAX) ? LOCK : IDLE;
        end
      end
      LOCK: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nxt = IDLE;
          fail_nxt  = '0;
          lock_nxt  = '0;
        end else begin
          lock_nxt = lock_cnt + LC_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is registered so it stays low throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      fail_cnt  <= '0;
      lock_cnt  <= '0;
      rsp_grant <= 1'b0;
      rsp_perm  <= 3'b000;
      op_zero_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state    <= state_nxt;
      ready_q  <= (state_nxt == IDLE);
      fail_cnt <= fail_nxt;
      lock_cnt <= lock_nxt;
      if (load_rsp) begin
        rsp_grant <= grant_c;
        rsp_perm  <= perm_c;
        op_zero_q <= (req_op == 3'b000);
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state == RESP);
  assign locked    = (state == LOCK);

endmodule

// File: tb/tb_access_permission_ctrl.sv
// Directed bench for access_permission_ctrl: grant/deny responses, backpressure,
// lockout timing, admin and zero-op edge cases, and reset in the middle of a response.
module tb_access_permission_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_user;
  logic [2:0] req_file;
  logic [2:0] req_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_grant;
  logic [2:0] rsp_perm;
  logic       locked;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  access_permission_ctrl #(
    .LEVEL_W     (3),
    .MAX_FAILS   (3),
    .LOCK_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_user  (req_user),
    .req_file  (req_file),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_grant (rsp_grant),
    .rsp_perm  (rsp_perm),
    .locked    (locked),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request at a falling edge and returns at the falling edge after acceptance.
  task automatic send(input logic [2:0] u, input logic [2:0] f, input logic [2:0] op);
    int waited;
    req_user  = u;
    req_file  = f;
    req_op    = op;
    req_valid = 1'b1;
    waited    = 0;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_latency", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic expect_rsp(input string tag, input logic [2:0] perm, input logic grant);
    check({tag, "_perm"}, {29'd0, rsp_perm}, {29'd0, perm});
    check({tag, "_grant"}, {31'd0, rsp_grant}, {31'd0, grant});
  endtask

  task automatic handshake(input string tag, input logic [1:0] exp_fail);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_fail_cnt"}, {30'd0, fail_cnt}, {30'd0, exp_fail});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int ready_leak;
    int rsp_leak;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_user  = 3'd0;
    req_file  = 3'd0;
    req_op    = 3'd0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_locked",    {31'd0, locked},    32'd0);
    check("rst_fail_cnt",  {30'd0, fail_cnt},  32'd0);
    check("rst_perm",      {29'd0, rsp_perm},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // Grant: u=5 f=3 op=RW -> perm RWX, granted
    send(3'd5, 3'd3, 3'b011);
    expect_rsp("grant", 3'b111, 1'b1);
    check("grant_busy", {31'd0, req_ready}, 32'd0);
    handshake("grant", 2'd0);
    check("grant_ready_back", {31'd0, req_ready}, 32'd1);

    // Deny with backpressure; inputs changed after acceptance must not matter
    send(3'd2, 3'd2, 3'b010);
    req_user = 3'd7;
    req_file = 3'd0;
    req_op   = 3'b001;
    for (int i = 0; i < 4; i++) begin
      expect_rsp("bp_hold", 3'b001, 1'b0);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    handshake("deny1", 2'd1);

    // Lockout: two more denials reach MAX_FAILS
    send(3'd1, 3'd4, 3'b001);
    expect_rsp("deny2", 3'b000, 1'b0);
    handshake("deny2", 2'd2);
    send(3'd3, 3'd3, 3'b010);
    expect_rsp("deny3", 3'b101, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("lock_entry", {31'd0, locked}, 32'd1);
    req_user   = 3'd7;
    req_file   = 3'd0;
    req_op     = 3'b111;
    req_valid  = 1'b1;
    cyc        = 0;
    ready_leak = 0;
    rsp_leak   = 0;
    while (locked === 1'b1 && cyc < 100) begin
      if (req_ready) ready_leak++;
      if (rsp_valid) rsp_leak++;
      cyc++;
      @(negedge clk);
    end
    check("lock_cycles",     cyc,        32'd16);
    check("lock_ready_leak", ready_leak, 32'd0);
    check("lock_rsp_leak",   rsp_leak,   32'd0);
    check("lock_exit_fail",  {30'd0, fail_cnt},  32'd0);
    check("lock_exit_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("post_lock_accept", {31'd0, rsp_valid}, 32'd1);
    expect_rsp("post_lock", 3'b111, 1'b1);
    handshake("post_lock", 2'd0);

    // Admin and edge cases
    send(3'd7, 3'd7, 3'b111);
    expect_rsp("admin", 3'b111, 1'b1);
    handshake("admin", 2'd0);
    send(3'd3, 3'd3, 3'b100);
    expect_rsp("exec_odd", 3'b101, 1'b1);
    handshake("exec_odd", 2'd0);
    send(3'd6, 3'd7, 3'b001);
    expect_rsp("below_file", 3'b000, 1'b0);
    handshake("below_file", 2'd1);
    send(3'd1, 3'd3, 3'b000);
    expect_rsp("op_zero", 3'b000, 1'b0);
    handshake("op_zero", 2'd1);
    send(3'd2, 3'd4, 3'b010);
    expect_rsp("deny_again", 3'b000, 1'b0);
    handshake("deny_again", 2'd2);
    send(3'd4, 3'd2, 3'b010);
    expect_rsp("clear_grant", 3'b011, 1'b1);
    handshake("clear_grant", 2'd0);

    // Reset while a response is pending
    send(3'd0, 3'd1, 3'b001);
    handshake("pre_rst", 2'd1);
    send(3'd0, 3'd2, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_fail",  {30'd0, fail_cnt},  32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_perm",  {29'd0, rsp_perm},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", {31'd0, req_ready}, 32'd1);
    send(3'd5, 3'd4, 3'b011);
    expect_rsp("after_rst", 3'b011, 1'b1);
    handshake("after_rst", 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
